mbc3_rtc_mapper: RTL and testbench
==================================

Name: mbc3_rtc_mapper

Overview:
Parametrised MBC3-class cartridge mapper for the Game Boy core. It widens the ROM and RAM bank registers to generic widths and adds multi-bank cartridge RAM. It also adds a real-time clock with a latch handshake, which the previous small mappers do not have. It sits between the CPU cart bus and the SDRAM ROM/CRAM address path, alongside the other mapper blocks.

Parameters:
ROM_BANK_W, 7, width of ROM bank register (16 KB banks; 7 gives 128 banks / 2 MB).
RAM_BANK_W, 2, width of RAM bank field (8 KB banks; 2 gives 4 banks / 32 KB).
TICK_DIV, 32768, ce_32k pulses per RTC second.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  mapper selected; when low, registers are held at reset values.
ce_cpu  in  1  CPU clock enable; qualifies cart_wr.
ce_32k  in  1  one-cycle 32.768 kHz strobe for the RTC.
cart_addr  in  16  CPU address.
cart_wr  in  1  CPU write strobe.
cart_di  in  8  CPU write data.
cart_mbc_type  in  8  cartridge header type byte.
rom_mask  in  ROM_BANK_W  ROM bank mirror mask.
ram_mask  in  RAM_BANK_W  RAM bank mirror mask.
cram_di  in  8  data read from CRAM.
cram_do  out  8  data returned to the CPU for A000-BFFF.
cram_addr  out  RAM_BANK_W+13  CRAM byte address.
cram_wr  out  1  CRAM write strobe.
mbc_bank  out  ROM_BANK_W+1  ROM 8 KB bank index.
ram_enabled  out  1  RAM/RTC access enabled.
has_battery  out  1  battery-backed cartridge.
has_rtc  out  1  RTC present.

Behaviour:
- Reset (reset_n low) or ~enable:
  - rom_bank=1, ram_sel=0, ram_en=0, latch_armed=0, prescaler=0.
  - Live RTC and latched RTC registers = 0.
  - Outputs follow combinationally from these values.
- Register writes take effect on the clk_sys edge where ce_cpu & cart_wr and the address is in range:
  - 0000-1FFF: ram_en <= (cart_di[3:0]==4'hA).
  - 2000-3FFF: rom_bank <= cart_di[ROM_BANK_W-1:0]; a value of 0 is stored as 1.
  - 4000-5FFF: ram_sel <= cart_di[3:0].
  - 6000-7FFF: latch handshake.
    - di==0 sets latch_armed.
    - di==1 while armed copies the live RTC into the latched registers (visible next cycle) and clears latch_armed.
    - Any other value clears latch_armed.
  - A000-BFFF with ram_en and ram_sel 8-C: write the live RTC register (8=S, 9=M, A=H, B=DL, C=DH).
    - A write to S also clears the prescaler.
- mbc_bank = {(addr[15:14]==0 ? 0 : rom_bank) & rom_mask, addr[13]}.
- cram_addr = {ram_sel[RAM_BANK_W-1:0] & ram_mask, addr[12:0]}.
- cram_wr = ce_cpu & cart_wr & ram_en & addr in A000-BFFF & ram_sel<4.
- cram_do:
  - 8'hFF when !ram_en.
  - cram_di when ram_sel<4.
  - Latched RTC register when ram_sel is 8-C; unused bits read 1 (S/M {2'b11,6b}, H {3'b111,5b}, DH {carry,halt,5'b11111,day8}).
  - 8'hFF otherwise.
- Prescaler:
  - Counts ce_32k pulses 0..TICK_DIV-1, then wraps to 0 and emits one tick.
  - Frozen while DH.halt=1.
- Tick increments S. Carry rules:
  - S: 59->0 and carries to M; 63->0 with no carry.
  - M: same as S.
  - H: 23->0 and carries to day; 31->0 with no carry.
  - Day (9-bit): 511->0 and sets DH.carry. DH.carry is sticky until the CPU writes it to 0.
- A CPU RTC write in the same cycle as a tick wins; that tick is discarded entirely.
- has_battery = type in {0x0F,0x10,0x13}.
- has_rtc = type in {0x0F,0x10}.
- ram_enabled = ram_en.
- Reset asserted mid-handshake clears latch_armed; the latched values then read 0.

Optional Feature:
MBC3_RTC_EN:
- Defined: RTC registers, prescaler and latch logic are present as above.
- Undefined: no RTC logic is synthesised.
  - ram_sel 8-C reads 8'hFF; writes to those selections are ignored.
  - 6000-7FFF writes are ignored.
  - has_rtc is tied 0.

Test Plan:
- Reset, then read 4000-7FFF -> mbc_bank={7'd1,addr[13]}. Write 2000=0x00 -> bank 1. Write 0x85 with rom_mask=7'h3F -> bank 0x05.
- Write 0000=0x0A, 4000=0x02, then read A123 with ram_mask=3 -> cram_addr=0x4123; cram_do=cram_di. Write 0000=0x00 -> cram_do=0xFF and cram_wr=0.
- Set S=58, pulse ce_32k 2*TICK_DIV times, latch 0->1, select 8 -> reads 0xC0 (0); M reads 0xC1.
- Write S=62, run 2 ticks -> S=0, M unchanged. Write DH.halt=1, run 40000 pulses -> S unchanged.
- Write day=511, H=23, M=59, S=59, run 1 tick, latch -> DL=0x00, DH=0xBE (carry=1, day8=0).
- Latch sequence 0,5,1 -> no latch; 0,1 -> latched. A tick coinciding with an S write -> S equals the written value and the prescaler restarts at 0.

Source files
------------

// File: rtl/mbc3_rtc_mapper.sv
// MBC3-class cartridge mapper: generic-width ROM/RAM banking plus an optional real-time clock.
// Define MBC3_RTC_EN to build the RTC counters, prescaler and latch handshake; otherwise no RTC logic exists.
module mbc3_rtc_mapper #(
    parameter int ROM_BANK_W = 7,
    parameter int RAM_BANK_W = 2,
    parameter int TICK_DIV   = 32768
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    ce_cpu,
    input  logic                    ce_32k,
    input  logic [15:0]             cart_addr,
    input  logic                    cart_wr,
    input  logic [7:0]              cart_di,
    input  logic [7:0]              cart_mbc_type,
    input  logic [ROM_BANK_W-1:0]   rom_mask,
    input  logic [RAM_BANK_W-1:0]   ram_mask,
    input  logic [7:0]              cram_di,
    output logic [7:0]              cram_do,
    output logic [RAM_BANK_W+12:0]  cram_addr,
    output logic                    cram_wr,
    output logic [ROM_BANK_W:0]     mbc_bank,
    output logic                    ram_enabled,
    output logic                    has_battery,
    output logic                    has_rtc
);

    logic [ROM_BANK_W-1:0] r_rom_bank;
    logic [3:0]            r_ram_sel;
    logic                  r_ram_en;

    logic w_cpu_wr;
    logic w_wr_ramen;
    logic w_wr_rom;
    logic w_wr_ramsel;
    logic w_wr_latch;
    logic w_cram_region;
    logic w_sel_ram;
    logic [ROM_BANK_W-1:0] w_rom_sel;
    logic w_unused;

    assign w_cpu_wr      = ce_cpu & cart_wr;
    assign w_wr_ramen    = w_cpu_wr & (cart_addr[15:13] == 3'b000);
    assign w_wr_rom      = w_cpu_wr & (cart_addr[15:13] == 3'b001);
    assign w_wr_ramsel   = w_cpu_wr & (cart_addr[15:13] == 3'b010);
    assign w_wr_latch    = w_cpu_wr & (cart_addr[15:13] == 3'b011);
    assign w_cram_region = (cart_addr[15:13] == 3'b101);
    assign w_sel_ram     = (r_ram_sel[3:2] == 2'b00);
    assign w_unused      = &{1'b0, cart_di, ce_32k};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_bank <= ROM_BANK_W'(1);
            r_ram_sel  <= 4'h0;
            r_ram_en   <= 1'b0;
        end else if (!enable) begin
            r_rom_bank <= ROM_BANK_W'(1);
            r_ram_sel  <= 4'h0;
            r_ram_en   <= 1'b0;
        end else begin
            if (w_wr_ramen)
                r_ram_en <= (cart_di[3:0] == 4'hA);
            // Bank 0 cannot be mapped into the switchable window; it aliases to bank 1.
            if (w_wr_rom)
                r_rom_bank <= (cart_di[ROM_BANK_W-1:0] == '0) ? ROM_BANK_W'(1)
                                                              : cart_di[ROM_BANK_W-1:0];
            if (w_wr_ramsel)
                r_ram_sel <= cart_di[3:0];
        end
    end

    assign w_rom_sel   = (cart_addr[15:14] == 2'b00) ? '0 : r_rom_bank;
    assign mbc_bank    = {w_rom_sel & rom_mask, cart_addr[13]};
    assign cram_addr   = {r_ram_sel[RAM_BANK_W-1:0] & ram_mask, cart_addr[12:0]};
    assign cram_wr     = w_cpu_wr & r_ram_en & w_cram_region & w_sel_ram;
    assign ram_enabled = r_ram_en;
    assign has_battery = (cart_mbc_type == 8'h0F) || (cart_mbc_type == 8'h10) ||
                         (cart_mbc_type == 8'h13);

`ifdef MBC3_RTC_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        LATCH_IDLE  = 1'b0,
        LATCH_ARMED = 1'b1
    } latch_state_t;

    latch_state_t r_latch_state;
    latch_state_t w_latch_next;

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hour;
    logic [8:0]    r_day;
    logic          r_halt;
    logic          r_carry;

    logic [5:0]    r_lat_sec;
    logic [5:0]    r_lat_min;
    logic [4:0]    r_lat_hour;
    logic [8:0]    r_lat_day;
    logic          r_lat_halt;
    logic          r_lat_carry;

    logic       w_sel_rtc;
    logic       w_rtc_wr;
    logic       w_presc_max;
    logic       w_tick;
    logic       w_latch_fire;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_hour_carry;
    logic       w_day_ovf;
    logic [5:0] w_sec_next;
    logic [5:0] w_min_next;
    logic [4:0] w_hour_next;
    logic [8:0] w_day_next;

    assign w_sel_rtc    = (r_ram_sel >= 4'h8) && (r_ram_sel <= 4'hC);
    assign w_rtc_wr     = w_cpu_wr & r_ram_en & w_cram_region & w_sel_rtc;
    assign w_presc_max  = (r_presc == PW'(TICK_DIV - 1));
    assign w_tick       = ce_32k & ~r_halt & w_presc_max;
    assign w_latch_fire = w_wr_latch && (r_latch_state == LATCH_ARMED) && (cart_di == 8'h01);

    // Out-of-range values (60-63, 24-31) count up to the field maximum and wrap without carrying.
    assign w_sec_carry  = (r_sec == 6'd59);
    assign w_sec_next   = ((r_sec == 6'd59) || (r_sec == 6'd63)) ? 6'd0 : r_sec + 6'd1;
    assign w_min_carry  = w_sec_carry && (r_min == 6'd59);
    assign w_min_next   = !w_sec_carry ? r_min :
                          ((r_min == 6'd59) || (r_min == 6'd63)) ? 6'd0 : r_min + 6'd1;
    assign w_hour_carry = w_min_carry && (r_hour == 5'd23);
    assign w_hour_next  = !w_min_carry ? r_hour :
                          ((r_hour == 5'd23) || (r_hour == 5'd31)) ? 5'd0 : r_hour + 5'd1;
    assign w_day_ovf    = w_hour_carry && (r_day == 9'd511);
    assign w_day_next   = w_hour_carry ? r_day + 9'd1 : r_day;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_presc <= '0;
        else if (!enable)
            r_presc <= '0;
        else if (w_rtc_wr && (r_ram_sel == 4'h8))
            r_presc <= '0;
        else if (ce_32k && !r_halt)
            r_presc <= w_presc_max ? '0 : r_presc + 1'b1;
    end

    // A CPU write to any RTC register takes priority and drops a coincident tick.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hour  <= 5'd0;
            r_day   <= 9'd0;
            r_halt  <= 1'b0;
            r_carry <= 1'b0;
        end else if (!enable) begin
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hour  <= 5'd0;
            r_day   <= 9'd0;
            r_halt  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_rtc_wr) begin
            case (r_ram_sel)
                4'h8: r_sec      <= cart_di[5:0];
                4'h9: r_min      <= cart_di[5:0];
                4'hA: r_hour     <= cart_di[4:0];
                4'hB: r_day[7:0] <= cart_di;
                4'hC: begin
                    r_day[8] <= cart_di[0];
                    r_halt   <= cart_di[6];
                    r_carry  <= cart_di[7];
                end
                default: ;
            endcase
        end else if (w_tick) begin
            r_sec  <= w_sec_next;
            r_min  <= w_min_next;
            r_hour <= w_hour_next;
            r_day  <= w_day_next;
            if (w_day_ovf)
                r_carry <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_sec   <= 6'd0;
            r_lat_min   <= 6'd0;
            r_lat_hour  <= 5'd0;
            r_lat_day   <= 9'd0;
            r_lat_halt  <= 1'b0;
            r_lat_carry <= 1'b0;
        end else if (!enable) begin
            r_lat_sec   <= 6'd0;
            r_lat_min   <= 6'd0;
            r_lat_hour  <= 5'd0;
            r_lat_day   <= 9'd0;
            r_lat_halt  <= 1'b0;
            r_lat_carry <= 1'b0;
        end else if (w_latch_fire) begin
            r_lat_sec   <= r_sec;
            r_lat_min   <= r_min;
            r_lat_hour  <= r_hour;
            r_lat_day   <= r_day;
            r_lat_halt  <= r_halt;
            r_lat_carry <= r_carry;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_latch_state <= LATCH_IDLE;
        else if (!enable)
            r_latch_state <= LATCH_IDLE;
        else
            r_latch_state <= w_latch_next;
    end

    // Writing 0 arms; any other value disarms, and a 1 while armed also fires the copy.
    always_comb begin
        w_latch_next = r_latch_state;
        if (w_wr_latch)
            w_latch_next = (cart_di == 8'h00) ? LATCH_ARMED : LATCH_IDLE;
    end

    assign has_rtc = (cart_mbc_type == 8'h0F) || (cart_mbc_type == 8'h10);
`else
    assign has_rtc = 1'b0;
`endif

    always_comb begin
        cram_do = 8'hFF;
        if (r_ram_en) begin
            if (w_sel_ram)
                cram_do = cram_di;
`ifdef MBC3_RTC_EN
            else begin
                case (r_ram_sel)
                    4'h8: cram_do = {2'b11, r_lat_sec};
                    4'h9: cram_do = {2'b11, r_lat_min};
                    4'hA: cram_do = {3'b111, r_lat_hour};
                    4'hB: cram_do = r_lat_day[7:0];
                    4'hC: cram_do = {r_lat_carry, r_lat_halt, 5'b11111, r_lat_day[8]};
                    default: cram_do = 8'hFF;
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_mbc3_rtc_mapper.sv
// Directed self-checking bench for mbc3_rtc_mapper; RTC checks are built only when MBC3_RTC_EN is defined.
module tb_mbc3_rtc_mapper;

    localparam int ROM_BANK_W = 7;
    localparam int RAM_BANK_W = 2;
    localparam int TICK_DIV   = 16;

    logic                   clk_sys = 1'b0;
    logic                   reset_n;
    logic                   enable;
    logic                   ce_cpu;
    logic                   ce_32k;
    logic [15:0]            cart_addr;
    logic                   cart_wr;
    logic [7:0]             cart_di;
    logic [7:0]             cart_mbc_type;
    logic [ROM_BANK_W-1:0]  rom_mask;
    logic [RAM_BANK_W-1:0]  ram_mask;
    logic [7:0]             cram_di;
    logic [7:0]             cram_do;
    logic [RAM_BANK_W+12:0] cram_addr;
    logic                   cram_wr;
    logic [ROM_BANK_W:0]    mbc_bank;
    logic                   ram_enabled;
    logic                   has_battery;
    logic                   has_rtc;

    int n_cmp = 0;
    int n_err = 0;

    mbc3_rtc_mapper #(
        .ROM_BANK_W(ROM_BANK_W),
        .RAM_BANK_W(RAM_BANK_W),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .enable       (enable),
        .ce_cpu       (ce_cpu),
        .ce_32k       (ce_32k),
        .cart_addr    (cart_addr),
        .cart_wr      (cart_wr),
        .cart_di      (cart_di),
        .cart_mbc_type(cart_mbc_type),
        .rom_mask     (rom_mask),
        .ram_mask     (ram_mask),
        .cram_di      (cram_di),
        .cram_do      (cram_do),
        .cram_addr    (cram_addr),
        .cram_wr      (cram_wr),
        .mbc_bank     (mbc_bank),
        .ram_enabled  (ram_enabled),
        .has_battery  (has_battery),
        .has_rtc      (has_rtc)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        cart_addr = a;
        cart_di   = d;
        ce_cpu    = 1'b1;
        cart_wr   = 1'b1;
        @(negedge clk_sys);
        ce_cpu    = 1'b0;
        cart_wr   = 1'b0;
    endtask

    task automatic cpu_wr_tick(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        cart_addr = a;
        cart_di   = d;
        ce_cpu    = 1'b1;
        cart_wr   = 1'b1;
        ce_32k    = 1'b1;
        @(negedge clk_sys);
        ce_cpu    = 1'b0;
        cart_wr   = 1'b0;
        ce_32k    = 1'b0;
    endtask

    task automatic pulses(input int n);
        @(negedge clk_sys);
        ce_32k = 1'b1;
        repeat (n) @(negedge clk_sys);
        ce_32k = 1'b0;
    endtask

    task automatic probe(input logic [15:0] a);
        @(negedge clk_sys);
        cart_addr = a;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] sel, input logic [7:0] exp);
        cpu_wr(16'h4000, sel);
        probe(16'hA000);
        check(tag, {24'd0, cram_do}, {24'd0, exp});
    endtask

    task automatic rtc_wr(input logic [7:0] sel, input logic [7:0] val);
        cpu_wr(16'h4000, sel);
        cpu_wr(16'hA000, val);
    endtask

    task automatic latch();
        cpu_wr(16'h6000, 8'h00);
        cpu_wr(16'h6000, 8'h01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b1;
        ce_cpu        = 1'b0;
        ce_32k        = 1'b0;
        cart_addr     = 16'h0000;
        cart_wr       = 1'b0;
        cart_di       = 8'h00;
        cart_mbc_type = 8'h13;
        rom_mask      = 7'h7F;
        ram_mask      = 2'h3;
        cram_di       = 8'h5A;

        repeat (2) @(negedge clk_sys);
        probe(16'h4000);
        check("rst_bank_4000", {24'd0, mbc_bank}, 32'h02);
        check("rst_ram_en", {31'd0, ram_enabled}, 32'd0);
        check("rst_cram_do", {24'd0, cram_do}, 32'hFF);
        @(negedge clk_sys);
        reset_n = 1'b1;

        probe(16'h6000);
        check("bank_6000", {24'd0, mbc_bank}, 32'h03);
        probe(16'h2000);
        check("bank_2000_fixed", {24'd0, mbc_bank}, 32'h01);

        check("bat_13", {31'd0, has_battery}, 32'd1);
        check("rtc_13", {31'd0, has_rtc}, 32'd0);
        cart_mbc_type = 8'h11;
        #1;
        check("bat_11", {31'd0, has_battery}, 32'd0);
        cart_mbc_type = 8'h0F;
        #1;
        check("bat_0f", {31'd0, has_battery}, 32'd1);
`ifdef MBC3_RTC_EN
        check("rtc_0f", {31'd0, has_rtc}, 32'd1);
`else
        check("rtc_0f_norrtc", {31'd0, has_rtc}, 32'd0);
`endif
        cart_mbc_type = 8'h10;

        cpu_wr(16'h2000, 8'h00);
        probe(16'h4000);
        check("bank_zero_as_one", {24'd0, mbc_bank}, 32'h02);
        rom_mask = 7'h3F;
        cpu_wr(16'h2000, 8'h85);
        probe(16'h4000);
        check("bank_85_mask3f", {24'd0, mbc_bank}, 32'h0A);
        probe(16'h7FFF);
        check("bank_85_hi", {24'd0, mbc_bank}, 32'h0B);
        rom_mask = 7'h7F;
        cpu_wr(16'h2000, 8'h7F);
        probe(16'h5000);
        check("bank_7f", {24'd0, mbc_bank}, 32'hFE);

        cpu_wr(16'h0000, 8'h0A);
        check("ram_en_on", {31'd0, ram_enabled}, 32'd1);
        cpu_wr(16'h4000, 8'h02);
        probe(16'hA123);
        check("cram_addr", {17'd0, cram_addr}, 32'h4123);
        check("cram_do_ram", {24'd0, cram_do}, 32'h5A);
        check("cram_wr_idle", {31'd0, cram_wr}, 32'd0);
        @(negedge clk_sys);
        ce_cpu = 1'b1; cart_wr = 1'b1; cart_di = 8'h33;
        #1;
        check("cram_wr_active", {31'd0, cram_wr}, 32'd1);
        @(negedge clk_sys);
        ce_cpu = 1'b0; cart_wr = 1'b0;
        ram_mask = 2'h1;
        #1;
        check("cram_addr_mask1", {17'd0, cram_addr}, 32'h0123);
        ram_mask = 2'h3;
        rd_chk("sel4_ff", 8'h04, 8'hFF);
        rd_chk("selD_ff", 8'h0D, 8'hFF);
        cpu_wr(16'h4000, 8'h03);
        cpu_wr(16'h0000, 8'h00);
        probe(16'hA000);
        check("cram_do_disabled", {24'd0, cram_do}, 32'hFF);
        @(negedge clk_sys);
        ce_cpu = 1'b1; cart_wr = 1'b1;
        #1;
        check("cram_wr_disabled", {31'd0, cram_wr}, 32'd0);
        @(negedge clk_sys);
        ce_cpu = 1'b0; cart_wr = 1'b0;
        cpu_wr(16'h0000, 8'h1A);
        check("ram_en_1a", {31'd0, ram_enabled}, 32'd1);

        @(negedge clk_sys);
        enable = 1'b0;
        @(negedge clk_sys);
        enable = 1'b1;
        probe(16'h4000);
        check("disable_bank", {24'd0, mbc_bank}, 32'h02);
        check("disable_ram_en", {31'd0, ram_enabled}, 32'd0);

        cpu_wr(16'h0000, 8'h0A);
`ifdef MBC3_RTC_EN
        rtc_wr(8'h08, 8'd58);
        pulses(2 * TICK_DIV);
        latch();
        rd_chk("s58_2ticks", 8'h08, 8'hC0);
        rd_chk("m_carry", 8'h09, 8'hC1);

        rtc_wr(8'h08, 8'd62);
        pulses(2 * TICK_DIV);
        latch();
        rd_chk("s62_wrap", 8'h08, 8'hC0);
        rd_chk("s62_no_carry", 8'h09, 8'hC1);

        rtc_wr(8'h08, 8'd10);
        rtc_wr(8'h0C, 8'h40);
        pulses(40);
        latch();
        rd_chk("halt_s", 8'h08, 8'hCA);
        rd_chk("halt_dh", 8'h0C, 8'h7E);

        rtc_wr(8'h0C, 8'h01);
        rtc_wr(8'h0B, 8'hFF);
        rtc_wr(8'h0A, 8'd23);
        rtc_wr(8'h09, 8'd59);
        rtc_wr(8'h08, 8'd59);
        pulses(TICK_DIV);
        latch();
        rd_chk("roll_dl", 8'h0B, 8'h00);
        rd_chk("roll_dh", 8'h0C, 8'hBE);
        rd_chk("roll_h", 8'h0A, 8'hE0);
        rd_chk("roll_m", 8'h09, 8'hC0);
        rd_chk("roll_s", 8'h08, 8'hC0);
        pulses(TICK_DIV);
        latch();
        rd_chk("carry_sticky", 8'h0C, 8'hBE);
        rtc_wr(8'h0C, 8'h00);
        latch();
        rd_chk("carry_cleared", 8'h0C, 8'h3E);

        rtc_wr(8'h08, 8'd5);
        cpu_wr(16'h6000, 8'h00);
        cpu_wr(16'h6000, 8'h05);
        cpu_wr(16'h6000, 8'h01);
        rd_chk("latch_broken", 8'h08, 8'hC1);
        latch();
        rd_chk("latch_ok", 8'h08, 8'hC5);

        rtc_wr(8'h08, 8'd10);
        pulses(TICK_DIV - 1);
        cpu_wr_tick(16'hA000, 8'd20);
        latch();
        rd_chk("tick_vs_write", 8'h08, 8'hD4);
        pulses(TICK_DIV - 1);
        latch();
        rd_chk("presc_restart", 8'h08, 8'hD4);
        pulses(1);
        latch();
        rd_chk("tick_after_wr", 8'h08, 8'hD5);

        pulses(5);
        rtc_wr(8'h08, 8'd30);
        pulses(TICK_DIV - 1);
        latch();
        rd_chk("s_wr_clears_presc", 8'h08, 8'hDE);
        pulses(1);
        latch();
        rd_chk("s_wr_then_tick", 8'h08, 8'hDF);

        rtc_wr(8'h0A, 8'd31);
        rtc_wr(8'h09, 8'd59);
        rtc_wr(8'h08, 8'd59);
        pulses(TICK_DIV);
        latch();
        rd_chk("h31_wrap", 8'h0A, 8'hE0);
        rd_chk("h31_no_day", 8'h0B, 8'h00);

        cpu_wr(16'h6000, 8'h00);
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        cpu_wr(16'h0000, 8'h0A);
        rtc_wr(8'h08, 8'd7);
        cpu_wr(16'h6000, 8'h01);
        rd_chk("rst_disarms", 8'h08, 8'hC0);
        rd_chk("rst_lat_h", 8'h0A, 8'hE0);
`else
        rtc_wr(8'h08, 8'h3A);
        latch();
        rd_chk("nortc_sel8", 8'h08, 8'hFF);
        rd_chk("nortc_selC", 8'h0C, 8'hFF);
        probe(16'hA000);
        @(negedge clk_sys);
        ce_cpu = 1'b1; cart_wr = 1'b1;
        #1;
        check("nortc_cram_wr", {31'd0, cram_wr}, 32'd0);
        @(negedge clk_sys);
        ce_cpu = 1'b0; cart_wr = 1'b0;
        rd_chk("nortc_sel3", 8'h03, 8'h5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
